// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Bundle of the loader's control, byte-stream and
//                instruction-memory write signals.
//                  start, num_words                 - load request
//                  in_valid, in_data, in_ready      - byte stream
//                  we, wr_addr, wr_data             - imem write port
//                  busy, done, err, core_hold       - status
//                The slave modport is the loader's view. The master modport
//                is the view of whatever drives the loader.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int ADDRESS_SIZE = 10,
    parameter int N            = 32
);
    logic                    start;
    logic [ADDRESS_SIZE-2:0] num_words;
    logic                    in_valid;
    logic [7:0]              in_data;
    logic                    in_ready;
    logic                    we;
    logic [ADDRESS_SIZE-1:0] wr_addr;
    logic [N-1:0]            wr_data;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic                    core_hold;

    modport slave (
        input  start, num_words, in_valid, in_data,
        output in_ready, we, wr_addr, wr_data, busy, done, err, core_hold
    );

    modport master (
        output start, num_words, in_valid, in_data,
        input  in_ready, we, wr_addr, wr_data, busy, done, err, core_hold
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-memory loader. Takes a byte stream on a
//                valid/ready handshake and assembles little-endian 32-bit
//                words. Each word is written to the instruction memory at
//                byte address 0, 4, 8, ... in order. core_hold is kept high
//                while a load is in progress.
//  Ports       : clk, rst (async, active high)
//                bus (imem_loader_if.slave):
//                  start/num_words         - load request (num_words 0..MAX_WORDS)
//                  in_valid/in_data/in_ready - byte stream
//                  we/wr_addr/wr_data      - imem write port, one cycle per word
//                  busy/done/err/core_hold - status; done and err are sticky
//  Options     : IMEM_LOADER_CHECKSUM_EN - after the last word, receive a
//                4-byte XOR checksum of all written words. A mismatch
//                sets err.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int ADDRESS_SIZE = 10,
    parameter int N            = 32   // must be 32: four bytes per word
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam int                      IDX_W     = ADDRESS_SIZE - 2;
    localparam logic [ADDRESS_SIZE-2:0] MAX_WORDS = (ADDRESS_SIZE-1)'(2**(ADDRESS_SIZE-2));
    localparam logic [ADDRESS_SIZE-2:0] ONE_WORD  = (ADDRESS_SIZE-1)'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_CHECK   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3
    } state_t;
`endif

    state_t                  r_state, w_state_next;
    logic [1:0]              r_byte_cnt, w_byte_cnt_next;
    logic [IDX_W-1:0]        r_word_idx, w_word_idx_next;
    logic [ADDRESS_SIZE-2:0] r_num_words, w_num_words_next;
    logic [N-1:0]            r_buf, w_buf_next;
    logic [ADDRESS_SIZE-1:0] r_wr_addr, w_wr_addr_next;
    logic [N-1:0]            r_wr_data, w_wr_data_next;
    logic                    r_in_ready, w_in_ready_next;
    logic                    r_we, w_we_next;
    logic                    r_busy, w_busy_next;
    logic                    r_done, w_done_next;
    logic                    r_err, w_err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [N-1:0]            r_xor, w_xor_next;
`endif

    logic                    w_fire;
    logic                    w_last;
    logic [N-1:0]            w_word_full;

    assign w_fire      = bus.in_valid & r_in_ready;
    // The current word is complete once the byte arriving now is placed in
    // the top lane on top of the three bytes already buffered.
    assign w_word_full = {bus.in_data, r_buf[N-9:0]};
    // The widening bit keeps word_idx+1 from wrapping when a full-capacity
    // load reaches its last word.
    assign w_last      = (({1'b0, r_word_idx} + ONE_WORD) == r_num_words);

    always_comb begin
        w_state_next     = r_state;
        w_byte_cnt_next  = r_byte_cnt;
        w_word_idx_next  = r_word_idx;
        w_num_words_next = r_num_words;
        w_buf_next       = r_buf;
        w_wr_addr_next   = r_wr_addr;
        w_wr_data_next   = r_wr_data;
        w_err_next       = r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_xor_next       = r_xor;
`endif

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_err_next       = 1'b0;
                    w_num_words_next = bus.num_words;
                    w_word_idx_next  = '0;
                    w_byte_cnt_next  = '0;
                    w_buf_next       = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_xor_next       = '0;
`endif
                    if (bus.num_words == '0) begin
                        w_state_next = S_DONE;
                    end else if (bus.num_words > MAX_WORDS) begin
                        w_err_next   = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_COLLECT;
                    end
                end
            end

            S_COLLECT: begin
                if (w_fire) begin
                    w_buf_next[{r_byte_cnt, 3'b000} +: 8] = bus.in_data;
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_next   = S_WRITE;
                        w_wr_addr_next = {r_word_idx, 2'b00};
                        w_wr_data_next = w_word_full;
                    end
                end
            end

            S_WRITE: begin
                w_byte_cnt_next = '0;
                w_buf_next      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_xor_next      = r_xor ^ r_wr_data;
`endif
                if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_state_next = S_CHECK;
`else
                    w_state_next = S_DONE;
`endif
                end else begin
                    w_word_idx_next = r_word_idx + IDX_W'(1);
                    w_state_next    = S_COLLECT;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The checksum word is only assembled and compared. It is
                // never written to memory.
                if (w_fire) begin
                    w_buf_next[{r_byte_cnt, 3'b000} +: 8] = bus.in_data;
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        if (w_word_full != r_xor) begin
                            w_err_next = 1'b1;
                        end
                        w_state_next = S_DONE;
                    end
                end
            end
`endif

            default: w_state_next = S_IDLE;
        endcase

        // Status outputs are decoded from the next state and then registered.
        // This way they line up with the state they describe.
        w_in_ready_next = (w_state_next == S_COLLECT);
        w_busy_next     = (w_state_next == S_COLLECT) || (w_state_next == S_WRITE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_in_ready_next = w_in_ready_next || (w_state_next == S_CHECK);
        w_busy_next     = w_busy_next     || (w_state_next == S_CHECK);
`endif
        w_we_next       = (w_state_next == S_WRITE);
        w_done_next     = (w_state_next == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= '0;
            r_word_idx  <= '0;
            r_num_words <= '0;
            r_buf       <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor       <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_byte_cnt  <= w_byte_cnt_next;
            r_word_idx  <= w_word_idx_next;
            r_num_words <= w_num_words_next;
            r_buf       <= w_buf_next;
            r_wr_addr   <= w_wr_addr_next;
            r_wr_data   <= w_wr_data_next;
            r_in_ready  <= w_in_ready_next;
            r_we        <= w_we_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor       <= w_xor_next;
`endif
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.we        = r_we;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.core_hold = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Each load builds its
//                expected write list (address = 4*j, data = little-endian
//                bytes of word j) and its expected final done/err from the
//                load request. A negedge monitor compares every write strobe
//                against that list.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;
    localparam int ADDRESS_SIZE = 10;
    localparam int N            = 32;
    localparam int MAX_WORDS    = 2**(ADDRESS_SIZE-2);

    logic clk = 1'b0;
    logic rst;

    imem_loader_if #(.ADDRESS_SIZE(ADDRESS_SIZE), .N(N)) bus();

    imem_loader #(.ADDRESS_SIZE(ADDRESS_SIZE), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int we_count = 0;

    logic [ADDRESS_SIZE-1:0] exp_addr_q[$];
    logic [31:0]             exp_data_q[$];
    logic [31:0]             stim_words[$];
    logic [ADDRESS_SIZE-1:0] last_addr = '0;
    logic [31:0]             last_data = '0;
    logic                    prev_we   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-port monitor: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            chk("core_hold_eq_busy", 64'(bus.core_hold), 64'(bus.busy));
            if (bus.we) begin
                we_count++;
                if (exp_addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_we: got we=1 at addr 0x%0h, expected no write", bus.wr_addr);
                end else begin
                    chk("wr_addr", 64'(bus.wr_addr), 64'(exp_addr_q.pop_front()));
                    chk("wr_data", 64'(bus.wr_data), 64'(exp_data_q.pop_front()));
                end
                chk("in_ready_in_write", 64'(bus.in_ready), 64'(0));
                chk("busy_in_write", 64'(bus.busy), 64'(1));
                last_addr = bus.wr_addr;
                last_data = bus.wr_data;
            end
            if (prev_we) begin
                chk("we_single_cycle", 64'(bus.we), 64'(0));
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (exp_addr_q.size() == 0) begin
                    chk("done_after_last_write", 64'(bus.done), 64'(1));
                    chk("busy_after_last_write", 64'(bus.busy), 64'(0));
                end
`endif
            end
            prev_we = bus.we;
        end
    end

    // Offers one byte after an optional random gap and returns once it is
    // accepted. Entry and exit are one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int n;
        if (gap_max > 0) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                chk("byte_accept_timeout", 64'(bus.in_ready), 64'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int nw);
        bus.start     = 1'b1;
        bus.num_words = (ADDRESS_SIZE-1)'(nw);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic fill_random(input int n);
        stim_words.delete();
        for (int i = 0; i < n; i++) stim_words.push_back($urandom);
    endtask

    // Runs one complete load of nw words from stim_words. A bad checksum is
    // sent as zero. With poke_start set, a stray start is pulsed mid-word.
    task automatic run_load(input int nw, input int gap_max, input bit bad_ck, input bit poke_start);
        bit          valid_n;
        bit          exp_err;
        int          exp_we;
        int          base;
        int          waited;
        logic [31:0] xsum;
        logic [31:0] ck_word;
        logic [31:0] w;

        valid_n = (nw >= 1) && (nw <= MAX_WORDS);
        exp_we  = valid_n ? nw : 0;
        exp_err = (nw > MAX_WORDS);
        xsum    = '0;
        for (int j = 0; j < exp_we; j++) begin
            exp_addr_q.push_back(ADDRESS_SIZE'(4 * j));
            exp_data_q.push_back(stim_words[j]);
            xsum = xsum ^ stim_words[j];
        end
        ck_word = bad_ck ? 32'h0 : xsum;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (valid_n && (ck_word != xsum)) exp_err = 1'b1;
`endif
        base = we_count;

        pulse_start(nw);
        @(negedge clk);
        chk("in_ready_after_start", 64'(bus.in_ready), 64'(valid_n));
        chk("busy_after_start", 64'(bus.busy), 64'(valid_n));
        if (!valid_n) begin
            chk("done_immediate", 64'(bus.done), 64'(1));
            chk("err_immediate", 64'(bus.err), 64'(exp_err));
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            for (int j = 0; j < nw; j++) begin
                w = stim_words[j];
                for (int b = 0; b < 4; b++) begin
                    send_byte(w[8*b +: 8], gap_max);
                    if (poke_start && j == 0 && b == 1) begin
                        pulse_start(0);
                        chk("busy_after_ignored_start", 64'(bus.busy), 64'(1));
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            for (int b = 0; b < 4; b++) send_byte(ck_word[8*b +: 8], gap_max);
`endif
            waited = 0;
            while (!bus.done && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            chk("done_reached", 64'(bus.done), 64'(1));
        end

        repeat (2) @(negedge clk);
        chk("final_done", 64'(bus.done), 64'(1));
        chk("final_err", 64'(bus.err), 64'(exp_err));
        chk("final_busy", 64'(bus.busy), 64'(0));
        chk("final_core_hold", 64'(bus.core_hold), 64'(0));
        chk("we_pulse_count", 64'(we_count - base), 64'(exp_we));
        chk("pending_writes", 64'(exp_addr_q.size()), 64'(0));
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.num_words = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst_we", 64'(bus.we), 64'(0));
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
        chk("rst_wr_data", 64'(bus.wr_data), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_core_hold", 64'(bus.core_hold), 64'(0));
        @(posedge clk);
        #1;

        // Single word, continuous stream.
        stim_words.delete();
        stim_words.push_back(32'h001101B3);
        run_load(1, 0, 1'b0, 1'b0);
        chk("single_addr", 64'(last_addr), 64'(10'h000));
        chk("single_data", 64'(last_data), 64'(32'h001101B3));

        // Three words with random stalls and a stray start mid-word.
        fill_random(3);
        run_load(3, 3, 1'b0, 1'b1);
        chk("multi_last_addr", 64'(last_addr), 64'(10'h008));

        // Boundary counts.
        run_load(0, 0, 1'b0, 1'b0);
        run_load(MAX_WORDS + 1, 0, 1'b0, 1'b0);
        run_load(511, 0, 1'b0, 1'b0);

        // Randomized loads. The first one also shows that err is cleared.
        for (int t = 0; t < 6; t++) begin
            int nw;
            nw = int'($urandom_range(8, 1));
            fill_random(nw);
            run_load(nw, int'($urandom_range(3, 0)), 1'b0, 1'b0);
        end

        // Full capacity.
        fill_random(MAX_WORDS);
        run_load(MAX_WORDS, 0, 1'b0, 1'b0);
        chk("full_last_addr", 64'(last_addr), 64'(10'h3FC));

        // Checksum pair: good checksum, then a zero checksum.
        stim_words.delete();
        stim_words.push_back(32'h00000013);
        stim_words.push_back(32'h00100093);
        run_load(2, 0, 1'b0, 1'b0);
        run_load(2, 1, 1'b1, 1'b0);

        // Reset in the middle of a word: no write may follow.
        fill_random(2);
        base = we_count;
        pulse_start(2);
        send_byte(stim_words[0][7:0], 0);
        send_byte(stim_words[0][15:8], 0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_we", 64'(bus.we), 64'(0));
        chk("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        chk("midrst_core_hold", 64'(bus.core_hold), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_we", 64'(we_count - base), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
